// File: rtl/control_sirena.sv
// Car-alarm sequencer: arm/disarm from the remote, timed intermittent siren.
// Optional alarm-memory flag enabled with CONTROL_SIRENA_MEMORIA_EN.
module control_sirena #(
    parameter int RETARDO_ARMADO = 8,
    parameter int T_MEDIO        = 2,
    parameter int T_SIRENA       = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mando,
    input  logic disparo,
    output logic armada,
    output logic sirena,
    output logic memoria
);

    localparam int MAX_CNT = (RETARDO_ARMADO > T_SIRENA) ?
                             RETARDO_ARMADO : T_SIRENA;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] FIN_ARMADO = CW'(RETARDO_ARMADO - 1);
    localparam logic [CW-1:0] FIN_SIRENA = CW'(T_SIRENA - 1);
    localparam logic [CW-1:0] FIN_FASE   = CW'(T_MEDIO - 1);
    localparam logic [CW-1:0] UNO        = CW'(1);

    typedef enum logic [2:0] {
        DESARMADA = 3'd0,
        ARMANDO   = 3'd1,
        ARMADA    = 3'd2,
        SONANDO   = 3'd3,
        SILENCIO  = 3'd4
    } estado_t;

    estado_t       estado_q;
    estado_t       estado_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] fase_q;
    logic [CW-1:0] fase_d;
    logic          tono_q;
    logic          tono_d;
    logic          mando_q;
    logic          pulsacion;

    // One pulse per press, however long the button is held.
    assign pulsacion = mando & ~mando_q;

    // State, counters and button history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= DESARMADA;
            cnt_q    <= '0;
            fase_q   <= '0;
            tono_q   <= 1'b0;
            mando_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            fase_q   <= fase_d;
            tono_q   <= tono_d;
            mando_q  <= mando;
        end
    end

    // Next state; a button press wins over disparo and timeouts.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        fase_d   = fase_q;
        tono_d   = tono_q;
        case (estado_q)
            DESARMADA: begin
                if (pulsacion) begin
                    estado_d = ARMANDO;
                    cnt_d    = '0;
                end
            end
            ARMANDO: begin
                if (pulsacion) begin
                    estado_d = DESARMADA;
                    cnt_d    = '0;
                end else if (cnt_q == FIN_ARMADO) begin
                    estado_d = ARMADA;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + UNO;
                end
            end
            ARMADA: begin
                if (pulsacion) begin
                    estado_d = DESARMADA;
                end else if (disparo) begin
                    estado_d = SONANDO;
                    cnt_d    = '0;
                    fase_d   = '0;
                    tono_d   = 1'b1;
                end
            end
            SONANDO: begin
                if (pulsacion) begin
                    estado_d = DESARMADA;
                    cnt_d    = '0;
                    fase_d   = '0;
                    tono_d   = 1'b0;
                end else if (cnt_q == FIN_SIRENA) begin
                    estado_d = SILENCIO;
                    cnt_d    = '0;
                    fase_d   = '0;
                    tono_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + UNO;
                    if (fase_q == FIN_FASE) begin
                        fase_d = '0;
                        tono_d = ~tono_q;
                    end else begin
                        fase_d = fase_q + UNO;
                    end
                end
            end
            SILENCIO: begin
                if (pulsacion) begin
                    estado_d = DESARMADA;
                end else if (!disparo) begin
                    estado_d = ARMADA;
                end
            end
            default: begin
                estado_d = DESARMADA;
                cnt_d    = '0;
                fase_d   = '0;
                tono_d   = 1'b0;
            end
        endcase
    end

    assign armada = (estado_q == ARMADA)  ||
                    (estado_q == SONANDO) ||
                    (estado_q == SILENCIO);
    assign sirena = (estado_q == SONANDO) && tono_q;

`ifdef CONTROL_SIRENA_MEMORIA_EN
    logic memoria_q;

    // Latch that the alarm fired; only a fresh arming clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memoria_q <= 1'b0;
        end else if (estado_q == ARMADA && estado_d == SONANDO) begin
            memoria_q <= 1'b1;
        end else if (estado_q == ARMANDO && estado_d == ARMADA) begin
            memoria_q <= 1'b0;
        end
    end

    assign memoria = memoria_q;
`else
    assign memoria = 1'b0;
`endif

endmodule

// File: tb/tb_control_sirena.sv
// Bench for control_sirena: timestamp-based model plus directed checks.
// Memory checks follow CONTROL_SIRENA_MEMORIA_EN.
module tb_control_sirena;

    localparam int R  = 8;
    localparam int TM = 2;
    localparam int TS = 12;

    localparam int M_DIS = 0;
    localparam int M_ARM = 1;
    localparam int M_OK  = 2;
    localparam int M_SON = 3;
    localparam int M_SIL = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mando = 1'b0;
    logic disparo = 1'b0;
    logic armada;
    logic sirena;
    logic memoria;

    int n_checks = 0;
    int n_pass = 0;

    int m_mode = M_DIS;
    int n_edge = 0;
    int t0 = 0;
    logic m_mq = 1'b0;
    logic m_mem = 1'b0;

    control_sirena #(
        .RETARDO_ARMADO(R),
        .T_MEDIO(TM),
        .T_SIRENA(TS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mando(mando),
        .disparo(disparo),
        .armada(armada),
        .sirena(sirena),
        .memoria(memoria)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: entry timestamps instead of counters.
    always @(posedge clk or negedge reset_n) begin
        logic puls;
        if (!reset_n) begin
            m_mode = M_DIS;
            m_mq   = 1'b0;
            m_mem  = 1'b0;
            n_edge = 0;
            t0     = 0;
        end else begin
            n_edge++;
            puls = mando && !m_mq;
            m_mq = mando;
            if (puls && m_mode != M_DIS) begin
                m_mode = M_DIS;
            end else begin
                case (m_mode)
                    M_DIS: if (puls) begin m_mode = M_ARM; t0 = n_edge; end
                    M_ARM: if (n_edge - t0 == R) begin m_mode = M_OK; m_mem = 1'b0; end
                    M_OK:  if (disparo) begin m_mode = M_SON; t0 = n_edge; m_mem = 1'b1; end
                    M_SON: if (n_edge - t0 == TS) m_mode = M_SIL;
                    M_SIL: if (!disparo) m_mode = M_OK;
                    default: m_mode = M_DIS;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic ea;
        logic es;
        if (reset_n) begin
            ea = (m_mode == M_OK) || (m_mode == M_SON) || (m_mode == M_SIL);
            es = (m_mode == M_SON) && (((n_edge - t0) / TM) % 2 == 0);
            chk("model_armada", armada, ea);
            chk("model_sirena", sirena, es);
`ifdef CONTROL_SIRENA_MEMORIA_EN
            chk("model_memoria", memoria, m_mem);
`else
            chk("model_memoria", memoria, 1'b0);
`endif
        end
    end

    initial begin
        logic [11:0] pat;
        int ones;
        int rises;
        pat = 12'b110011001100;

        // Reset state
        #3;
        chk("rst_armada", armada, 1'b0);
        chk("rst_sirena", sirena, 1'b0);
        chk("rst_memoria", memoria, 1'b0);
        #9 reset_n = 1'b1;
        tick(2);

        // Arming with button held 5 cycles
        mando = 1'b1;
        for (int i = 0; i <= R; i++) begin
            tick(1);
            if (i == 4) mando = 1'b0;
            chk("arm_delay", armada, (i == R) ? 1'b1 : 1'b0);
        end
        tick(3);
        chk("arm_stays", armada, 1'b1);

        // Single-cycle trigger: siren pattern
        disparo = 1'b1;
        tick(1);
        disparo = 1'b0;
        for (int k = 0; k < TS; k++) begin
            chk("siren_pat", sirena, pat[11-k]);
            tick(1);
        end
        chk("post_burst_sirena", sirena, 1'b0);
        chk("post_burst_armada", armada, 1'b1);
        tick(1);
        disparo = 1'b1;
        tick(1);
        disparo = 1'b0;
        chk("retrigger", sirena, 1'b1);
        tick(14);

        // Held trigger: single burst
        disparo = 1'b1;
        ones = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (sirena) ones++;
        end
        chk("held_one_burst", (ones == 6), 1'b1);
        chk("held_silent", sirena, 1'b0);
        chk("held_armed", armada, 1'b1);
        disparo = 1'b0;
        tick(1);
        disparo = 1'b1;
        tick(1);
        disparo = 1'b0;
        chk("held_rearm", sirena, 1'b1);

        // Disarm during siren cycle 5
        tick(4);
        mando = 1'b1;
        tick(1);
        mando = 1'b0;
        chk("disarm_sirena", sirena, 1'b0);
        chk("disarm_armada", armada, 1'b0);
`ifdef CONTROL_SIRENA_MEMORIA_EN
        chk("mem_after_disarm", memoria, 1'b1);
`endif
        tick(2);

        // Cancel during arming
        mando = 1'b1;
        tick(1);
        mando = 1'b0;
        tick(2);
        mando = 1'b1;
        tick(1);
        mando = 1'b0;
        rises = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (armada) rises++;
        end
        chk("cancel_never_armed", (rises == 0), 1'b1);

        // Priority: press and trigger together in ARMADA
        mando = 1'b1;
        tick(1);
        mando = 1'b0;
        tick(R);
        chk("rearm_armada", armada, 1'b1);
`ifdef CONTROL_SIRENA_MEMORIA_EN
        chk("mem_cleared", memoria, 1'b0);
`endif
        mando = 1'b1;
        disparo = 1'b1;
        tick(1);
        mando = 1'b0;
        disparo = 1'b0;
        chk("prio_armada", armada, 1'b0);
        chk("prio_sirena", sirena, 1'b0);
        tick(2);

        // Async reset mid-siren
        mando = 1'b1;
        tick(1);
        mando = 1'b0;
        tick(R);
        disparo = 1'b1;
        tick(1);
        disparo = 1'b0;
        tick(4);
        chk("pre_reset_sirena", sirena, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_sirena", sirena, 1'b0);
        chk("areset_armada", armada, 1'b0);
        chk("areset_memoria", memoria, 1'b0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick(4);
        chk("after_reset_idle", armada, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
